// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the IF/ID pipeline register and its load-use hazard logic.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_R      = 7'b011_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_LUI    = 7'b011_0111;
    localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the IF/ID instruction and a load sitting in ID/EX.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic       valid,
    input  logic [6:0] opcode,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_register_rd,
    output logic       hazard
);

    logic uses_rs1;
    logic uses_rs2;
    logic rs1_match;
    logic rs2_match;

    // Only U/J formats ignore rs1; unknown opcodes are treated conservatively as readers.
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        if ((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL)) begin
            uses_rs1 = 1'b0;
        end
        if ((opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH)) begin
            uses_rs2 = 1'b1;
        end
    end

    assign rs1_match = uses_rs1 && (rs1 == id_ex_register_rd);
    assign rs2_match = uses_rs2 && (rs2 == id_ex_register_rd);

    assign hazard = valid && id_ex_memread && (id_ex_register_rd != 5'd0)
                    && (rs1_match || rs2_match);

endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall, branch flush and saturating event counters.
module if_id_hazard #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [31:0]      instr_in,
    input  logic             branch_taken,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_register_rd,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic [4:0]       if_id_register_rs1,
    output logic [4:0]       if_id_register_rs2,
    output logic [4:0]       if_id_register_rd,
    output logic             if_id_valid,
    output logic             pc_write,
    output logic             control_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic            hazard;
    logic            flush;
    logic            stall;
    logic [XLEN-1:0] pc_reg;
    logic [31:0]     instr_reg;
    logic            valid_reg;

    hazard_detect u_hazard_detect (
        .valid             (valid_reg),
        .opcode            (instr_reg[6:0]),
        .rs1               (instr_reg[19:15]),
        .rs2               (instr_reg[24:20]),
        .id_ex_memread     (id_ex_memread),
        .id_ex_register_rd (id_ex_register_rd),
        .hazard            (hazard)
    );

    // A redirect overrides the stall: the stalled instruction is on the wrong path anyway.
    assign flush = branch_taken;
    assign stall = hazard && !branch_taken;

    assign pc_write       = ~hazard | branch_taken;
    assign control_bubble = hazard | branch_taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg    <= '0;
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (flush) begin
            pc_reg    <= pc_in;
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (!stall) begin
            pc_reg    <= pc_in;
            instr_reg <= instr_in;
            valid_reg <= 1'b1;
        end
    end

    assign if_id_pc           = pc_reg;
    assign if_id_instr        = instr_reg;
    assign if_id_valid        = valid_reg;
    assign if_id_register_rs1 = instr_reg[19:15];
    assign if_id_register_rs2 = instr_reg[24:20];
    assign if_id_register_rd  = instr_reg[11:7];

    // Slot 0 counts stalls, slot 1 counts flushes; stall is already masked by flush.
    logic [1:0]            event_hit;
    logic [1:0][CNT_W-1:0] cnt_bus;

    assign event_hit = {flush, stall};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (event_hit[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            assign cnt_bus[gi] = cnt_reg;
        end
    endgenerate

    assign stall_count = cnt_bus[0];
    assign flush_count = cnt_bus[1];

endmodule

// File: tb/tb_if_id_hazard.sv
// Directed and randomized bench for if_id_hazard against a behavioural pipeline-register model.
module tb_if_id_hazard;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        branch_taken;
    logic        id_ex_memread;
    logic [4:0]  id_ex_register_rd;

    logic [31:0] if_id_pc, if_id_instr;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        if_id_valid, pc_write, control_bubble;
    logic [15:0] stall_count, flush_count;

    logic [31:0] s_pc, s_instr;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic        s_valid, s_pc_write, s_bubble;
    logic [1:0]  s_stall_count, s_flush_count;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [31:0] m_pc, m_instr;
    logic        m_valid;
    int          m_stall, m_flush;

    always #5 clk = ~clk;

    if_id_hazard dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .instr_in(instr_in),
        .branch_taken(branch_taken), .id_ex_memread(id_ex_memread),
        .id_ex_register_rd(id_ex_register_rd),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_register_rs1(rs1_o), .if_id_register_rs2(rs2_o),
        .if_id_register_rd(rd_o), .if_id_valid(if_id_valid),
        .pc_write(pc_write), .control_bubble(control_bubble),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    if_id_hazard #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .instr_in(instr_in),
        .branch_taken(branch_taken), .id_ex_memread(id_ex_memread),
        .id_ex_register_rd(id_ex_register_rd),
        .if_id_pc(s_pc), .if_id_instr(s_instr),
        .if_id_register_rs1(s_rs1), .if_id_register_rs2(s_rs2),
        .if_id_register_rd(s_rd), .if_id_valid(s_valid),
        .pc_write(s_pc_write), .control_bubble(s_bubble),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Register-read rules straight from the ISA formats.
    function automatic bit reads_rs1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return (op == 7'h33 || op == 7'h23 || op == 7'h63);
    endfunction

    function automatic bit model_hazard();
        logic [4:0] r1, r2;
        r1 = m_instr[19:15];
        r2 = m_instr[24:20];
        if (!m_valid || !id_ex_memread || id_ex_register_rd == 5'd0) return 1'b0;
        return (reads_rs1(m_instr[6:0]) && r1 == id_ex_register_rd) ||
               (reads_rs2(m_instr[6:0]) && r2 == id_ex_register_rd);
    endfunction

    function automatic logic [31:0] sat_u(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // One clock of stimulus: drive, check combinational outputs, clock, check registers.
    task automatic step(input string name, input logic rst, input logic [31:0] pc,
                        input logic [31:0] ins, input logic br, input logic mr,
                        input logic [4:0] exrd);
        bit hz;
        rst_n = rst; pc_in = pc; instr_in = ins; branch_taken = br;
        id_ex_memread = mr; id_ex_register_rd = exrd;
        #1;
        hz = model_hazard();
        check({name, ".pc_write"}, {31'd0, pc_write}, {31'd0, (!hz || br)});
        check({name, ".bubble"}, {31'd0, control_bubble}, {31'd0, (hz || br)});
        check({name, ".sat_pc_write"}, {31'd0, s_pc_write}, {31'd0, (!hz || br)});
        @(posedge clk);
        if (!rst) begin
            m_pc = 0; m_instr = NOP; m_valid = 0; m_stall = 0; m_flush = 0;
        end else if (br) begin
            m_pc = pc; m_instr = NOP; m_valid = 0; m_flush++;
        end else if (hz) begin
            m_stall++;
        end else begin
            m_pc = pc; m_instr = ins; m_valid = 1;
        end
        #1;
        check({name, ".pc"}, if_id_pc, m_pc);
        check({name, ".instr"}, if_id_instr, m_instr);
        check({name, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check({name, ".rs1"}, {27'd0, rs1_o}, {27'd0, m_instr[19:15]});
        check({name, ".rs2"}, {27'd0, rs2_o}, {27'd0, m_instr[24:20]});
        check({name, ".rd"}, {27'd0, rd_o}, {27'd0, m_instr[11:7]});
        check({name, ".stall_count"}, {16'd0, stall_count}, sat_u(m_stall, 65535));
        check({name, ".flush_count"}, {16'd0, flush_count}, sat_u(m_flush, 65535));
        check({name, ".sat_stall"}, {30'd0, s_stall_count}, sat_u(m_stall, 3));
        check({name, ".sat_flush"}, {30'd0, s_flush_count}, sat_u(m_flush, 3));
        $display("[TB] %s rst_n=%0b pc=%h instr=%h br=%0b mr=%0b exrd=%0d hz=%0b -> pc=%h instr=%h v=%0b st=%0d fl=%0d",
                 name, rst, pc, ins, br, mr, exrd, hz, if_id_pc, if_id_instr, if_id_valid,
                 stall_count, flush_count);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] w;
        logic [4:0]  picks [4];
        ops = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0B};
        picks = '{5'd0, 5'd5, 5'd7, 5'd9};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[19:15] = picks[$urandom_range(0, 3)];
        w[24:20] = picks[$urandom_range(0, 3)];
        return w;
    endfunction

    localparam logic [31:0] ADD_X6_X5_X7 = 32'h0072_8333;
    localparam logic [31:0] LUI_X5       = 32'h0002_82B7;

    initial begin
        logic [4:0] rd_pick [4];
        rd_pick = '{5'd0, 5'd5, 5'd7, 5'd9};
        m_pc = 0; m_instr = NOP; m_valid = 0; m_stall = 0; m_flush = 0;
        rst_n = 1'b0; pc_in = '0; instr_in = '0; branch_taken = 1'b0;
        id_ex_memread = 1'b0; id_ex_register_rd = '0;
        @(negedge clk);

        // Reset held two cycles
        step("reset0", 0, 32'h100, ADD_X6_X5_X7, 0, 1, 5'd5);
        step("reset1", 0, 32'h104, ADD_X6_X5_X7, 0, 1, 5'd5);

        // Load-use: add x6,x5,x7 behind lw x5
        step("load_add", 1, 32'h10, ADD_X6_X5_X7, 0, 0, 5'd0);
        step("lu_stall", 1, 32'h14, 32'h0000_0033, 0, 1, 5'd5);
        step("lu_advance", 1, 32'h14, 32'h0000_0033, 0, 0, 5'd5);

        // No false hazards
        step("load_add2", 1, 32'h18, ADD_X6_X5_X7, 0, 0, 5'd0);
        step("rd_zero", 1, 32'h1C, LUI_X5, 0, 1, 5'd0);
        step("lui_vs_rd5", 1, 32'h20, 32'h0000_0013, 0, 1, 5'd5);

        // Flush
        step("flush", 1, 32'h40, ADD_X6_X5_X7, 1, 0, 5'd0);

        // Stall and flush together
        step("load_add3", 1, 32'h44, ADD_X6_X5_X7, 0, 0, 5'd0);
        step("stall_flush", 1, 32'h80, ADD_X6_X5_X7, 1, 1, 5'd7);

        // Saturation: five back-to-back stalls
        step("load_add4", 1, 32'h84, ADD_X6_X5_X7, 0, 0, 5'd0);
        for (int i = 0; i < 5; i++) step("sat_stall", 1, 32'h88, 32'h0, 0, 1, 5'd7);

        // Reset in the middle of a stall
        step("mid_reset", 0, 32'h90, 32'h0, 0, 1, 5'd7);
        step("after_reset", 1, 32'h94, ADD_X6_X5_X7, 0, 1, 5'd5);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 49) != 0), $urandom, rand_instr(),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
                 rd_pick[$urandom_range(0, 3)]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_id_hazard.md
IF_ID_HAZARD -- requirements
Module: if_id_hazard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath and PC width.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction value (ADDI x0,x0,0) loaded on reset and flush.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall and flush statistics counters.
REQ-004 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-006 The block SHALL have port pc_in, input, XLEN, the fetch-stage PC.
REQ-007 The block SHALL have port instr_in, input, 32, the fetched instruction.
REQ-008 The block SHALL have port branch_taken, input, 1, redirect from execute; flushes the fetched instruction.
REQ-009 The block SHALL have port id_ex_memread, input, 1, the load flag currently held in the ID/EX register.
REQ-010 The block SHALL have port id_ex_register_rd, input, 5, the destination register currently held in ID/EX.
REQ-011 The block SHALL have port if_id_pc, output, XLEN, the registered PC.
REQ-012 The block SHALL have port if_id_instr, output, 32, the registered instruction.
REQ-013 The block SHALL have ports if_id_register_rs1, if_id_register_rs2 and if_id_register_rd, output, 5 each, equal to instr[19:15], instr[24:20] and instr[11:7] of if_id_instr.
REQ-014 The block SHALL have port if_id_valid, output, 1, set when if_id_instr is a real instruction.
REQ-015 The block SHALL have port pc_write, output, 1, fetch PC update enable (0 = hold PC).
REQ-016 The block SHALL have port control_bubble, output, 1, which forces the control word into ID/EX to all-zero.
REQ-017 The block SHALL have ports stall_count and flush_count, output, CNT_W each, the statistics counters.

Function
REQ-018 The block SHALL compute uses_rs1 as 0 only for opcodes LUI, AUIPC and JAL.
REQ-019 The block SHALL compute uses_rs2 as 1 only for opcodes OP (R-type), STORE and BRANCH.
REQ-020 The block SHALL assert hazard combinationally when all of the following hold: if_id_valid is 1; id_ex_memread is 1; id_ex_register_rd != 0; and (uses_rs1 and rs1 == id_ex_register_rd) or (uses_rs2 and rs2 == id_ex_register_rd).
REQ-021 The block SHALL drive pc_write = ~hazard | branch_taken and control_bubble = hazard | branch_taken.
REQ-022 The block SHALL give the register update the following priority on each rising clk edge: reset, then flush, then stall, then load.
REQ-023 On flush (branch_taken = 1), the block SHALL load if_id_instr = NOP_INSTR, if_id_valid = 0 and if_id_pc = pc_in, regardless of hazard.
REQ-024 On stall (hazard = 1 and branch_taken = 0), the block SHALL hold if_id_pc, if_id_instr and if_id_valid unchanged.
REQ-025 On load (neither flush nor stall), the block SHALL capture if_id_pc = pc_in, if_id_instr = instr_in and if_id_valid = 1, giving one-cycle latency.
REQ-026 A load-use stall SHALL last exactly one cycle when ID/EX receives the bubble; the block SHALL NOT carry any hidden state that extends the stall.
REQ-027 stall_count SHALL increment on each edge where a stall occurs, saturating at all-ones.
REQ-028 flush_count SHALL increment on each edge where a flush occurs, saturating at all-ones.
REQ-029 When stall and flush coincide, only flush_count SHALL increment.

Reset
REQ-030 While rst_n = 0 at a rising edge, the block SHALL set if_id_pc = 0, if_id_instr = NOP_INSTR, if_id_valid = 0, stall_count = 0 and flush_count = 0.
REQ-031 During and immediately after reset, hazard SHALL be 0 (because valid = 0), so pc_write = 1 and control_bubble = branch_taken.
REQ-032 Reset asserted in the middle of a stall SHALL take priority and clear the stalled instruction.

Structure
REQ-033 Package riscv_pkg SHALL hold NOP_INSTR and the opcode constants OP_LOAD, OP_IMM, OP_STORE, OP_R, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL and OP_JALR.
REQ-034 The combinational hazard logic (REQ-018 to REQ-020) SHALL be one sub-module, hazard_detect.
REQ-035 The pipeline register and the counters SHALL remain in if_id_hazard.

Verification
REQ-036 Reset check: hold rst_n = 0 for 2 cycles -> if_id_instr = 32'h13, valid = 0, counters = 0, pc_write = 1.
REQ-037 Load-use stall: ID/EX holds lw to x5 (memread = 1, rd = 5); IF/ID holds add x6,x5,x7 -> hazard for one cycle; pc_write = 0; control_bubble = 1; IF/ID held; stall_count = 1; next cycle memread = 0 and the instruction advances.
REQ-038 No false hazard: id_ex_rd = 0 with memread = 1, or lui x5 in IF/ID against rd = 5 -> no stall.
REQ-039 Flush: branch_taken = 1 with pc_in = 0x40 -> next cycle if_id_instr = NOP, valid = 0, if_id_pc = 0x40, flush_count = 1.
REQ-040 Simultaneous stall and flush: hazard conditions true with branch_taken = 1 -> flush wins, pc_write = 1, only flush_count increments.
REQ-041 Saturation: CNT_W = 2 and 5 consecutive stall events -> stall_count reaches 3 and holds at 3.
